// File: rtl/qconv_states_pkg.sv
// Shared types and default timing for the qconv sequencing FSM.
// Optional build feature: QCONV_FSM_CYCLE_COUNT_EN adds a run-length cycle counter.
package qconv_states_pkg;

  // Phase encoding as seen on the state output
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALC  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_OC_HIGH_NUM  = 4;
  localparam int DEF_LOAD_CYCLES  = 8;
  localparam int DEF_CALC_CYCLES  = 16;
  localparam int DEF_STORE_CYCLES = 4;
  localparam int CYCLE_COUNT_W    = 16;

endpackage

// File: rtl/qconv_phase_counter.sv
// Phase counter shared by LOAD/CALC/STORE. The caller muxes in the phase
// length; terminal flags the last cycle of the phase (cnt == limit-1), after
// which the counter wraps back to zero for the next phase.
module qconv_phase_counter #(
  parameter int CntBitWidth = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [CntBitWidth-1:0] limit,
  output logic [CntBitWidth-1:0] cnt,
  output logic                   terminal
);

  logic [CntBitWidth-1:0] cnt_reg;

  assign cnt      = cnt_reg;
  assign terminal = (cnt_reg == (limit - 1'b1));

  // Count up; restart from zero on clear or at the end of a phase
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_reg <= '0;
    end else if (clear || terminal) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/qconv_states_fsm.sv
// Top-level sequencing FSM for the qconv datapath: walks the output-channel
// tiles through LOAD, CALC and STORE, then pulses finish for one cycle.
// Note: rst_n is an active-high synchronous reset despite its name.
// Optional build feature: QCONV_FSM_CYCLE_COUNT_EN adds output cycle_count.
module qconv_states_fsm
  import qconv_states_pkg::*;
#(
  parameter int OcHighBitWidth = 4,
  parameter int OcHighNum      = DEF_OC_HIGH_NUM,
  parameter int LoadCycles     = DEF_LOAD_CYCLES,
  parameter int CalcCycles     = DEF_CALC_CYCLES,
  parameter int StoreCycles    = DEF_STORE_CYCLES,
  parameter int CntBitWidth    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      finish,
  output logic [2:0]                state,
  output logic [OcHighBitWidth-1:0] oc_high,
  output logic                      load_en,
  output logic                      calc_en,
  output logic                      calc_first,
  output logic                      calc_last,
  output logic                      store_en
`ifdef QCONV_FSM_CYCLE_COUNT_EN
  ,
  output logic [CYCLE_COUNT_W-1:0]  cycle_count
`endif
);

  localparam logic [OcHighBitWidth-1:0] LastTile = OcHighBitWidth'(OcHighNum - 1);

  state_t                  state_reg, state_next;
  logic [OcHighBitWidth-1:0] oc_high_reg, oc_high_next;
  logic [CntBitWidth-1:0]  cnt;
  logic [CntBitWidth-1:0]  cnt_limit;
  logic                    cnt_clear;
  logic                    cnt_terminal;
  logic                    working;

  assign working = (state_reg == ST_LOAD) || (state_reg == ST_CALC) ||
                   (state_reg == ST_STORE);

  // Phase length for the shared counter; idle/done keep it parked at zero
  always_comb begin
    cnt_limit = CntBitWidth'(1);
    cnt_clear = !working;
    case (state_reg)
      ST_LOAD:  cnt_limit = CntBitWidth'(LoadCycles);
      ST_CALC:  cnt_limit = CntBitWidth'(CalcCycles);
      ST_STORE: cnt_limit = CntBitWidth'(StoreCycles);
      default:  cnt_limit = CntBitWidth'(1);
    endcase
  end

  qconv_phase_counter #(
    .CntBitWidth(CntBitWidth)
  ) u_phase_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .limit   (cnt_limit),
    .cnt     (cnt),
    .terminal(cnt_terminal)
  );

  // State and tile-index registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= ST_IDLE;
      oc_high_reg <= '0;
    end else begin
      state_reg   <= state_next;
      oc_high_reg <= oc_high_next;
    end
  end

  // Next-state and tile-index logic; illegal encodings fall back to IDLE
  always_comb begin
    state_next   = state_reg;
    oc_high_next = oc_high_reg;
    case (state_reg)
      ST_IDLE: begin
        oc_high_next = '0;
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (cnt_terminal) state_next = ST_CALC;
      end
      ST_CALC: begin
        if (cnt_terminal) state_next = ST_STORE;
      end
      ST_STORE: begin
        if (cnt_terminal) begin
          if (oc_high_reg == LastTile) begin
            state_next = ST_DONE;
          end else begin
            state_next   = ST_LOAD;
            oc_high_next = oc_high_reg + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next   = ST_IDLE;
        oc_high_next = '0;
      end
      default: begin
        state_next   = ST_IDLE;
        oc_high_next = '0;
      end
    endcase
  end

  // Moore outputs decoded purely from registers
  assign state      = state_reg;
  assign oc_high    = oc_high_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign finish     = (state_reg == ST_DONE);
  assign load_en    = (state_reg == ST_LOAD);
  assign calc_en    = (state_reg == ST_CALC);
  assign store_en   = (state_reg == ST_STORE);
  assign calc_first = calc_en && (cnt == '0);
  assign calc_last  = calc_en && (cnt == CntBitWidth'(CalcCycles - 1));

`ifdef QCONV_FSM_CYCLE_COUNT_EN
  logic [CYCLE_COUNT_W-1:0] cycle_count_reg;

  assign cycle_count = cycle_count_reg;

  // Length of the current/last run in working cycles, saturating
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cycle_count_reg <= '0;
    end else if ((state_reg == ST_IDLE) && start) begin
      cycle_count_reg <= '0;
    end else if (working && (cycle_count_reg != {CYCLE_COUNT_W{1'b1}})) begin
      cycle_count_reg <= cycle_count_reg + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_qconv_states_fsm.sv
// Scoreboard bench for qconv_states_fsm: a position-in-run model predicts the
// outputs for every cycle; a monitor compares them on the falling edge.
// Optional build feature: QCONV_FSM_CYCLE_COUNT_EN also checks cycle_count.
module tb_qconv_states_fsm;

  localparam int NT    = 4;
  localparam int LC    = 8;
  localparam int CC    = 16;
  localparam int SC    = 4;
  localparam int PER   = LC + CC + SC;
  localparam int TOTAL = NT * PER;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  oc;
    logic        busy;
    logic        fin;
    logic        ld;
    logic        ca;
    logic        first;
    logic        last;
    logic        str;
    logic [15:0] cc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        busy, finish, load_en, calc_en, calc_first, calc_last, store_en;
  logic [2:0]  state;
  logic [3:0]  oc_high;
  logic [15:0] cc_dut;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  // Model: -1 idle, 0..TOTAL-1 working cycle index in the run, TOTAL = done
  int m_pos = -1;
  int m_cc  = 0;

  always #5 clk = ~clk;

`ifdef QCONV_FSM_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
  assign cc_dut = cycle_count;
`else
  assign cc_dut = 16'd0;
`endif

  qconv_states_fsm #(
    .OcHighBitWidth(4), .OcHighNum(NT), .LoadCycles(LC),
    .CalcCycles(CC), .StoreCycles(SC), .CntBitWidth(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .finish(finish),
    .state(state), .oc_high(oc_high), .load_en(load_en), .calc_en(calc_en),
    .calc_first(calc_first), .calc_last(calc_last), .store_en(store_en)
`ifdef QCONV_FSM_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  function automatic exp_t expect_of(int pos, int cnt_val);
    exp_t e;
    int off;
    e = '0;
`ifdef QCONV_FSM_CYCLE_COUNT_EN
    e.cc = 16'(cnt_val);
`else
    e.cc = 16'd0;
`endif
    if (pos < 0) begin
      e.st = 3'd0;
    end else if (pos >= TOTAL) begin
      e.st = 3'd4; e.busy = 1'b1; e.fin = 1'b1; e.oc = 4'(NT - 1);
    end else begin
      e.busy = 1'b1;
      e.oc = 4'(pos / PER);
      off = pos % PER;
      if (off < LC) begin
        e.st = 3'd1; e.ld = 1'b1;
      end else if (off < LC + CC) begin
        e.st = 3'd2; e.ca = 1'b1;
        e.first = (off == LC);
        e.last = (off == LC + CC - 1);
      end else begin
        e.st = 3'd3; e.str = 1'b1;
      end
    end
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, queue expectation
  task automatic step(input logic s, input logic r);
    start = s;
    rst_n = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_pos = -1; m_cc = 0;
    end else if (m_pos < 0) begin
      if (s) begin m_pos = 0; m_cc = 0; end
    end else if (m_pos >= TOTAL) begin
      m_pos = -1;
    end else begin
      if (m_cc < 16'hFFFF) m_cc = m_cc + 1;
      m_pos = m_pos + 1;
    end
    sb_q.push_back(expect_of(m_pos, m_cc));
  endtask

  // Monitor: every falling edge with a pending expectation is a comparison
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {state, oc_high, busy, finish, load_en, calc_en, calc_first,
             calc_last, store_en, cc_dut};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL trace t=%0t got st=%0d oc=%0d busy=%b fin=%b ld=%b ca=%b first=%b last=%b st_en=%b cc=%0d need st=%0d oc=%0d busy=%b fin=%b ld=%b ca=%b first=%b last=%b st_en=%b cc=%0d",
                   $time, a.st, a.oc, a.busy, a.fin, a.ld, a.ca, a.first, a.last, a.str, a.cc,
                   e.st, e.oc, e.busy, e.fin, e.ld, e.ca, e.first, e.last, e.str, e.cc);
        end
      end
    end
  end

  initial begin
    // Reset for two cycles
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    // Nominal run with a stray start at the 50th edge after E0
    step(1'b1, 1'b0);
    for (int i = 1; i < 120; i++) step(i == 50, 1'b0);
    // Reset during tile 2 CALC, then a full run afterwards
    step(1'b1, 1'b0);
    for (int i = 1; i < 80; i++) step(1'b0, i == 70);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 1; i < 120; i++) step(1'b0, 1'b0);
    // Start held high: back-to-back runs
    for (int i = 0; i < 240; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    // Random sparse starts and resets
    for (int i = 0; i < 600; i++)
      step(($urandom % 25) == 0, ($urandom % 250) == 0);
    step(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending need=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
